frog_move_ctrl: RTL and testbench
=================================

Name: frog_move_ctrl

Overview:
- Per-frame position controller for the frog sprite.
- Turns keypad directions into timed hops, clamps the frog to the screen, and handles death/respawn and goal reach.
- Drives ObjectStartX/ObjectStartY of the frog drawing block; sits between the keypad decoder and the VGA object layer.
- All motion updates happen only on startOfFrame, so the drawn sprite never tears mid-frame.

Parameters:
- START_X, 307, respawn X (top-left pixel)
- START_Y, 448, respawn Y
- MAX_X, 614, largest legal X (640 − 26 sprite width)
- MAX_Y, 454, largest legal Y (480 − 26)
- GOAL_Y, 0, Y at which a completed hop scores
- STEP, 4, pixels moved per frame during a hop
- HOP_FRAMES, 8, frames per hop (hop length 32 px)
- DEAD_FRAMES, 60, frames frozen after a hit

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- key_up  in  1  level, direction request
- key_down  in  1  level, direction request
- key_left  in  1  level, direction request
- key_right  in  1  level, direction request
- hit  in  1  one-cycle collision pulse from the collision block
- topLeftX  out  11  frog X, to ObjectStartX
- topLeftY  out  11  frog Y, to ObjectStartY
- hop_busy  out  1  high while in HOP
- frog_dead  out  1  high while in DEAD
- goal_pulse  out  1  one-cycle pulse when the goal is reached
- death_pulse  out  1  one-cycle pulse on accepted hit

Behaviour:
- Reset values: topLeftX=START_X, topLeftY=START_Y; all other outputs 0; state IDLE; counters 0.
- FSM states: IDLE, HOP, DEAD.
- IDLE, on startOfFrame with any key high:
  - Priority up > down > left > right.
  - Direction is latched only if the move is legal: up needs Y>0, down needs Y<MAX_Y, left needs X>0, right needs X<MAX_X.
  - Legal: go to HOP with frame counter = 0; position does not change this frame.
  - Illegal direction: stay in IDLE; lower-priority keys are not considered.
- HOP, on each startOfFrame:
  - Move the latched coordinate by STEP.
  - Saturate at 0 / MAX_X / MAX_Y; arithmetic is done in 12-bit signed, then clamped to 11 bits.
  - Increment the counter. When the counter reaches HOP_FRAMES−1 (i.e. on the HOP_FRAMES-th move), return to IDLE.
  - Keys are ignored during HOP.
  - A key still held at the end of a hop starts a new hop on the next startOfFrame.
- Goal: if a hop ends with topLeftY==GOAL_Y:
  - goal_pulse fires the cycle after that startOfFrame.
  - Position reloads to START_X/START_Y in the same cycle; state IDLE.
- hit in IDLE or HOP:
  - Next cycle: DEAD, death_pulse=1 for one cycle, frog_dead=1, dead counter=0.
  - Position freezes where it is.
- hit in DEAD: ignored.
- hit and startOfFrame in the same cycle: hit wins; no position update.
- DEAD: counter increments on each startOfFrame. After DEAD_FRAMES frames, load START_X/START_Y, clear frog_dead, go to IDLE.
- Output timing: all outputs are registered; a position change is visible one CLK after its startOfFrame.
- RESETn asserted mid-hop or mid-death: immediately returns every register to its reset value.

Optional Feature:
- Macro FROG_LOG_RIDE_EN.
- Defined:
  - Adds inputs on_log (1 bit) and log_dx (4-bit signed, pixels per frame).
  - In IDLE, on startOfFrame with on_log=1 and no hop starting, X += log_dx.
  - If the result is <0 or >MAX_X, the frog dies exactly as on hit (death_pulse, DEAD); X is clamped.
  - HOP ignores log_dx.
- Not defined: the ports are absent and X changes only by hops and respawn.

Test Plan:
- Reset, then 3 frames with no keys -> topLeftX=307, topLeftY=448 held; hop_busy=0.
- key_up held for 1 frame -> Y goes 444, 440, … 416 over 8 frames; hop_busy high for 8 frames, then IDLE.
- From X=612, key_right hop -> X saturates at 614 and stays for the rest of the hop. Key_left at X=0 -> no hop, hop_busy stays 0.
- hit pulse during hop frame 3 -> death_pulse one cycle; position frozen for 60 frames, then 307/448 and IDLE. A second hit while in DEAD is ignored.
- Y=32, key_up hop completes at Y=0 -> goal_pulse one cycle; position reloads to 307/448.
- With FROG_LOG_RIDE_EN: X=610, on_log=1, log_dx=+3 -> X=613, next frame death_pulse and X clamped at 614. With log_dx=−2 from X=1 -> death.

Source files
------------

// File: rtl/frog_move_ctrl.sv
// -----------------------------------------------------------------------------
// frog_move_ctrl
// Per-frame position controller for the frog sprite. Keypad directions become
// timed hops of HOP_FRAMES moves of STEP pixels. The frog is clamped to the
// screen, frozen for DEAD_FRAMES frames after a hit and then respawned. A hop
// that ends on GOAL_Y scores and respawns. Position only changes on
// startOfFrame, so the drawn sprite never tears mid-frame.
//
// Optional feature: define FROG_LOG_RIDE_EN to add log riding. The log moves
// the idle frog by log_dx per frame, and the frog dies if the log carries it
// off screen.
//
// Ports:
//   CLK, RESETn                 clock, asynchronous active-low reset
//   startOfFrame                one-cycle pulse per VGA frame
//   key_up/down/left/right      direction request levels
//   hit                         one-cycle collision pulse
//   on_log, log_dx              (FROG_LOG_RIDE_EN only) log ride request, signed dx
//   topLeftX, topLeftY          frog position (11 bit) to the object layer
//   hop_busy, frog_dead         state flags (HOP, DEAD)
//   goal_pulse, death_pulse     one-cycle event pulses
// -----------------------------------------------------------------------------
module frog_move_ctrl #(
   parameter int START_X     = 307,
   parameter int START_Y     = 448,
   parameter int MAX_X       = 614,
   parameter int MAX_Y       = 454,
   parameter int GOAL_Y      = 0,
   parameter int STEP        = 4,
   parameter int HOP_FRAMES  = 8,
   parameter int DEAD_FRAMES = 60
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              startOfFrame,
   input  logic              key_up,
   input  logic              key_down,
   input  logic              key_left,
   input  logic              key_right,
   input  logic              hit,
`ifdef FROG_LOG_RIDE_EN
   input  logic              on_log,
   input  logic signed [3:0] log_dx,
`endif
   output logic [10:0]       topLeftX,
   output logic [10:0]       topLeftY,
   output logic              hop_busy,
   output logic              frog_dead,
   output logic              goal_pulse,
   output logic              death_pulse
);

   typedef enum logic [1:0] {IDLE, HOP, DEAD} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   localparam logic [10:0]        START_X_C   = 11'(START_X);
   localparam logic [10:0]        START_Y_C   = 11'(START_Y);
   localparam logic [10:0]        MAX_X_C     = 11'(MAX_X);
   localparam logic [10:0]        MAX_Y_C     = 11'(MAX_Y);
   localparam logic [10:0]        GOAL_Y_C    = 11'(GOAL_Y);
   localparam logic signed [11:0] STEP_C      = 12'(STEP);
   localparam logic [7:0]         HOP_LAST    = 8'(HOP_FRAMES - 1);
   localparam logic [7:0]         DEAD_LAST   = 8'(DEAD_FRAMES - 1);

   state_t      state_reg, state_next;
   dir_t        dir_reg, dir_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [10:0] x_reg, x_next;
   logic [10:0] y_reg, y_next;
   logic        goal_reg, goal_next;
   logic        death_reg, death_next;

   // Key decode: the highest-priority pressed key alone decides; if its move
   // is illegal no lower-priority key is tried.
   dir_t key_dir;
   logic key_any;
   logic key_legal;

   always_comb begin
      key_any   = key_up | key_down | key_left | key_right;
      key_dir   = DIR_RIGHT;
      key_legal = (x_reg < MAX_X_C);
      if (key_up) begin
         key_dir   = DIR_UP;
         key_legal = (y_reg != 11'd0);
      end else if (key_down) begin
         key_dir   = DIR_DOWN;
         key_legal = (y_reg < MAX_Y_C);
      end else if (key_left) begin
         key_dir   = DIR_LEFT;
         key_legal = (x_reg != 11'd0);
      end
   end

   // One hop step on the latched axis, done in 12-bit signed and saturated.
   logic              vertical;
   logic signed [11:0] coord_s, moved_s, limit_s;
   logic [10:0]        moved_c;

   always_comb begin
      vertical = (dir_reg == DIR_UP) || (dir_reg == DIR_DOWN);
      coord_s  = vertical ? $signed({1'b0, y_reg}) : $signed({1'b0, x_reg});
      limit_s  = vertical ? $signed({1'b0, MAX_Y_C}) : $signed({1'b0, MAX_X_C});
      if ((dir_reg == DIR_UP) || (dir_reg == DIR_LEFT))
         moved_s = coord_s - STEP_C;
      else
         moved_s = coord_s + STEP_C;
      if (moved_s < 12'sd0)
         moved_c = 11'd0;
      else if (moved_s > limit_s)
         moved_c = limit_s[10:0];
      else
         moved_c = moved_s[10:0];
   end

`ifdef FROG_LOG_RIDE_EN
   logic signed [11:0] log_sum;
   always_comb log_sum = $signed({1'b0, x_reg}) + $signed({{8{log_dx[3]}}, log_dx});
`endif

   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      cnt_next   = cnt_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      goal_next  = 1'b0;
      death_next = 1'b0;

      case (state_reg)
         IDLE, HOP: begin
            if (hit) begin
               // Hit beats a simultaneous startOfFrame: position freezes.
               state_next = DEAD;
               death_next = 1'b1;
               cnt_next   = 8'd0;
            end else if (startOfFrame && (state_reg == IDLE)) begin
               if (key_any && key_legal) begin
                  state_next = HOP;
                  dir_next   = key_dir;
                  cnt_next   = 8'd0;
               end
`ifdef FROG_LOG_RIDE_EN
               else if (on_log) begin
                  if (log_sum < 12'sd0) begin
                     x_next     = 11'd0;
                     state_next = DEAD;
                     death_next = 1'b1;
                     cnt_next   = 8'd0;
                  end else if (log_sum > $signed({1'b0, MAX_X_C})) begin
                     x_next     = MAX_X_C;
                     state_next = DEAD;
                     death_next = 1'b1;
                     cnt_next   = 8'd0;
                  end else begin
                     x_next = log_sum[10:0];
                  end
               end
`endif
            end else if (startOfFrame) begin
               if (vertical) y_next = moved_c;
               else          x_next = moved_c;
               cnt_next = cnt_reg + 8'd1;
               if (cnt_reg == HOP_LAST) begin
                  state_next = IDLE;
                  cnt_next   = 8'd0;
                  if ((vertical ? moved_c : y_reg) == GOAL_Y_C) begin
                     goal_next = 1'b1;
                     x_next    = START_X_C;
                     y_next    = START_Y_C;
                  end
               end
            end
         end
         DEAD: begin
            if (startOfFrame) begin
               if (cnt_reg == DEAD_LAST) begin
                  state_next = IDLE;
                  cnt_next   = 8'd0;
                  x_next     = START_X_C;
                  y_next     = START_Y_C;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_reg <= IDLE;
         dir_reg   <= DIR_UP;
         cnt_reg   <= 8'd0;
         x_reg     <= START_X_C;
         y_reg     <= START_Y_C;
         goal_reg  <= 1'b0;
         death_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         cnt_reg   <= cnt_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         goal_reg  <= goal_next;
         death_reg <= death_next;
      end
   end

   assign topLeftX    = x_reg;
   assign topLeftY    = y_reg;
   assign hop_busy    = (state_reg == HOP);
   assign frog_dead   = (state_reg == DEAD);
   assign goal_pulse  = goal_reg;
   assign death_pulse = death_reg;

endmodule

// File: tb/tb_frog_move_ctrl.sv
module tb_frog_move_ctrl;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic        hit = 1'b0;
`ifdef FROG_LOG_RIDE_EN
   logic        on_log = 1'b0;
   logic signed [3:0] log_dx = 4'sd0;
`endif
   logic [10:0] topLeftX, topLeftY;
   logic        hop_busy, frog_dead, goal_pulse, death_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

   frog_move_ctrl dut (
      .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .hit(hit),
`ifdef FROG_LOG_RIDE_EN
      .on_log(on_log), .log_dx(log_dx),
`endif
      .topLeftX(topLeftX), .topLeftY(topLeftY), .hop_busy(hop_busy),
      .frog_dead(frog_dead), .goal_pulse(goal_pulse), .death_pulse(death_pulse)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic frame;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
   endtask

   task automatic set_key(input int d, input logic v);
      case (d)
         D_UP:    key_up = v;
         D_DOWN:  key_down = v;
         D_LEFT:  key_left = v;
         default: key_right = v;
      endcase
   endtask

   task automatic start_hop(input int d);
      set_key(d, 1'b1);
      frame();
      set_key(d, 1'b0);
   endtask

   task automatic hop(input int d);
      start_hop(d);
      repeat (8) frame();
   endtask

   task automatic do_reset;
      RESETn = 1'b0;
      tick();
      RESETn = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      RESETn = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (topLeftX !== 11'd307 || topLeftY !== 11'd448) begin
         $display("FAIL reset_pos: got %0d/%0d want 307/448", topLeftX, topLeftY); n_fail++;
      end
      n_tests++;
      if ({hop_busy, frog_dead, goal_pulse, death_pulse} !== 4'b0000) begin
         $display("FAIL reset_flags: got %b want 0000", {hop_busy, frog_dead, goal_pulse, death_pulse}); n_fail++;
      end
      RESETn = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         frame();
         n_tests++;
         if (topLeftX !== 11'd307 || topLeftY !== 11'd448 || hop_busy !== 1'b0) begin
            $display("FAIL idle_hold[%0d]: got %0d/%0d busy %b want 307/448 busy 0", i, topLeftX, topLeftY, hop_busy); n_fail++;
         end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_hop_up;
      start_hop(D_UP);
      n_tests++;
      if (hop_busy !== 1'b1 || topLeftY !== 11'd448) begin
         $display("FAIL hop_start: got busy %b Y %0d want busy 1 Y 448", hop_busy, topLeftY); n_fail++;
      end
      for (int i = 1; i <= 8; i++) begin
         frame();
         n_tests++;
         if (topLeftY !== 11'(448 - 4 * i) || hop_busy !== (i < 8)) begin
            $display("FAIL hop_up[%0d]: got Y %0d busy %b want Y %0d busy %b", i, topLeftY, hop_busy, 448 - 4 * i, (i < 8)); n_fail++;
         end
      end
      $display("[TB] test_hop_up done");
   endtask

   task automatic test_right_clamp;
      int e;
      do_reset();
      repeat (9) hop(D_RIGHT);
      n_tests++;
      if (topLeftX !== 11'd595) begin
         $display("FAIL right_pre: got X %0d want 595", topLeftX); n_fail++;
      end
      start_hop(D_RIGHT);
      for (int i = 1; i <= 8; i++) begin
         frame();
         e = (595 + 4 * i > 614) ? 614 : 595 + 4 * i;
         n_tests++;
         if (topLeftX !== 11'(e)) begin
            $display("FAIL right_clamp[%0d]: got X %0d want %0d", i, topLeftX, e); n_fail++;
         end
      end
      start_hop(D_RIGHT);
      n_tests++;
      if (hop_busy !== 1'b0 || topLeftX !== 11'd614) begin
         $display("FAIL right_edge: got busy %b X %0d want busy 0 X 614", hop_busy, topLeftX); n_fail++;
      end
      $display("[TB] test_right_clamp done");
   endtask

   task automatic test_left_clamp;
      int e;
      do_reset();
      repeat (9) hop(D_LEFT);
      n_tests++;
      if (topLeftX !== 11'd19) begin
         $display("FAIL left_pre: got X %0d want 19", topLeftX); n_fail++;
      end
      start_hop(D_LEFT);
      for (int i = 1; i <= 8; i++) begin
         frame();
         e = (19 - 4 * i < 0) ? 0 : 19 - 4 * i;
         n_tests++;
         if (topLeftX !== 11'(e)) begin
            $display("FAIL left_clamp[%0d]: got X %0d want %0d", i, topLeftX, e); n_fail++;
         end
      end
      start_hop(D_LEFT);
      n_tests++;
      if (hop_busy !== 1'b0 || topLeftX !== 11'd0) begin
         $display("FAIL left_edge: got busy %b X %0d want busy 0 X 0", hop_busy, topLeftX); n_fail++;
      end
      $display("[TB] test_left_clamp done");
   endtask

   task automatic test_priority;
      do_reset();
      hop(D_DOWN);
      n_tests++;
      if (topLeftY !== 11'd454) begin
         $display("FAIL down_clamp: got Y %0d want 454", topLeftY); n_fail++;
      end
      // Down is illegal at MAX_Y and must block the lower-priority right key.
      key_down = 1'b1; key_right = 1'b1;
      frame();
      key_down = 1'b0; key_right = 1'b0;
      n_tests++;
      if (hop_busy !== 1'b0 || topLeftX !== 11'd307) begin
         $display("FAIL priority_block: got busy %b X %0d want busy 0 X 307", hop_busy, topLeftX); n_fail++;
      end
      $display("[TB] test_priority done");
   endtask

   task automatic test_hit;
      do_reset();
      start_hop(D_UP);
      repeat (3) frame();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      n_tests++;
      if (death_pulse !== 1'b1 || frog_dead !== 1'b1 || hop_busy !== 1'b0 || topLeftY !== 11'd436) begin
         $display("FAIL hit_enter: got dp %b dead %b busy %b Y %0d want 1 1 0 436", death_pulse, frog_dead, hop_busy, topLeftY); n_fail++;
      end
      tick();
      n_tests++;
      if (death_pulse !== 1'b0) begin
         $display("FAIL death_pulse_width: got %b want 0", death_pulse); n_fail++;
      end
      hit = 1'b1;
      tick();
      hit = 1'b0;
      n_tests++;
      if (death_pulse !== 1'b0 || frog_dead !== 1'b1) begin
         $display("FAIL hit_in_dead: got dp %b dead %b want 0 1", death_pulse, frog_dead); n_fail++;
      end
      repeat (59) frame();
      n_tests++;
      if (frog_dead !== 1'b1 || topLeftY !== 11'd436 || topLeftX !== 11'd307) begin
         $display("FAIL dead_59: got dead %b X %0d Y %0d want 1 307 436", frog_dead, topLeftX, topLeftY); n_fail++;
      end
      frame();
      n_tests++;
      if (frog_dead !== 1'b0 || topLeftY !== 11'd448 || topLeftX !== 11'd307 || hop_busy !== 1'b0) begin
         $display("FAIL respawn: got dead %b X %0d Y %0d busy %b want 0 307 448 0", frog_dead, topLeftX, topLeftY, hop_busy); n_fail++;
      end
      $display("[TB] test_hit done");
   endtask

   task automatic test_hit_with_frame;
      do_reset();
      key_up = 1'b1; hit = 1'b1; startOfFrame = 1'b1;
      tick();
      key_up = 1'b0; hit = 1'b0; startOfFrame = 1'b0;
      n_tests++;
      if (death_pulse !== 1'b1 || frog_dead !== 1'b1 || hop_busy !== 1'b0 || topLeftY !== 11'd448) begin
         $display("FAIL hit_vs_frame: got dp %b dead %b busy %b Y %0d want 1 1 0 448", death_pulse, frog_dead, hop_busy, topLeftY); n_fail++;
      end
      $display("[TB] test_hit_with_frame done");
   endtask

   task automatic test_goal;
      do_reset();
      repeat (13) hop(D_UP);
      n_tests++;
      if (topLeftY !== 11'd32) begin
         $display("FAIL goal_pre: got Y %0d want 32", topLeftY); n_fail++;
      end
      start_hop(D_UP);
      repeat (7) frame();
      n_tests++;
      if (topLeftY !== 11'd4 || goal_pulse !== 1'b0) begin
         $display("FAIL goal_approach: got Y %0d goal %b want 4 0", topLeftY, goal_pulse); n_fail++;
      end
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      n_tests++;
      if (goal_pulse !== 1'b1 || topLeftX !== 11'd307 || topLeftY !== 11'd448 || hop_busy !== 1'b0) begin
         $display("FAIL goal_hit: got goal %b X %0d Y %0d busy %b want 1 307 448 0", goal_pulse, topLeftX, topLeftY, hop_busy); n_fail++;
      end
      tick();
      n_tests++;
      if (goal_pulse !== 1'b0) begin
         $display("FAIL goal_width: got %b want 0", goal_pulse); n_fail++;
      end
      $display("[TB] test_goal done");
   endtask

   task automatic test_async_reset;
      do_reset();
      start_hop(D_UP);
      frame();
      frame();
      n_tests++;
      if (topLeftY !== 11'd440 || hop_busy !== 1'b1) begin
         $display("FAIL mid_hop: got Y %0d busy %b want 440 1", topLeftY, hop_busy); n_fail++;
      end
      #2 RESETn = 1'b0;
      #1;
      n_tests++;
      if (topLeftY !== 11'd448 || hop_busy !== 1'b0) begin
         $display("FAIL async_reset: got Y %0d busy %b want 448 0", topLeftY, hop_busy); n_fail++;
      end
      tick();
      RESETn = 1'b1;
      tick();
      $display("[TB] test_async_reset done");
   endtask

`ifdef FROG_LOG_RIDE_EN
   task automatic test_log;
      do_reset();
      on_log = 1'b1;
      log_dx = 4'sd7;
      repeat (43) frame();
      log_dx = 4'sd3;
      frame();
      frame();
      n_tests++;
      if (topLeftX !== 11'd614 || frog_dead !== 1'b0) begin
         $display("FAIL log_right: got X %0d dead %b want 614 0", topLeftX, frog_dead); n_fail++;
      end
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      n_tests++;
      if (death_pulse !== 1'b1 || frog_dead !== 1'b1 || topLeftX !== 11'd614) begin
         $display("FAIL log_right_death: got dp %b dead %b X %0d want 1 1 614", death_pulse, frog_dead, topLeftX); n_fail++;
      end
      do_reset();
      log_dx = -4'sd7;
      repeat (43) frame();
      log_dx = -4'sd2;
      repeat (3) frame();
      n_tests++;
      if (topLeftX !== 11'd0 || frog_dead !== 1'b0) begin
         $display("FAIL log_left: got X %0d dead %b want 0 0", topLeftX, frog_dead); n_fail++;
      end
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      n_tests++;
      if (death_pulse !== 1'b1 || frog_dead !== 1'b1 || topLeftX !== 11'd0) begin
         $display("FAIL log_left_death: got dp %b dead %b X %0d want 1 1 0", death_pulse, frog_dead, topLeftX); n_fail++;
      end
      on_log = 1'b0;
      log_dx = 4'sd0;
      $display("[TB] test_log done");
   endtask
`endif

   initial begin
      test_reset();
      test_hop_up();
      test_right_clamp();
      test_left_clamp();
      test_priority();
      test_hit();
      test_hit_with_frame();
      test_goal();
      test_async_reset();
`ifdef FROG_LOG_RIDE_EN
      test_log();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
